// File: rtl/memory_responder.sv
// memory_responder: 16x8 RAM behind a 4-bit MAR; reads are registered with 1-cycle latency, requests are levels with no backpressure.
// Optional bus write path and conflict flag are compiled in with RAM_WRITE_EN.
module memory_responder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mar_load,
   input  logic       ram_read,
`ifdef RAM_WRITE_EN
   input  logic       ram_write,
`endif
   input  logic [7:0] bus_in,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [7:0] prog_data,
   output logic [7:0] bus_out,
   output logic       bus_drive,
   output logic       data_valid,
   output logic [3:0] mar_q,
   output logic       req_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
`ifdef RAM_WRITE_EN
      WRITE = 2'd2,
`endif
      READ  = 2'd1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] mar_d;
   logic [7:0] bus_out_q, bus_out_d;
   logic       bus_drive_q, bus_drive_d;
   logic       data_valid_q, data_valid_d;
   logic [7:0] mem_q [16];
   logic [7:0] rd_dat;

`ifdef RAM_WRITE_EN
   logic       req_err_q, req_err_d;
   logic       ram_wr_en;
`else
   logic       bus_hi_unused;
   assign bus_hi_unused = ^bus_in[7:4];
`endif

   assign rd_dat     = mem_q[mar_q];
   assign bus_out    = bus_out_q;
   assign bus_drive  = bus_drive_q;
   assign data_valid = data_valid_q;

   always_comb begin
      state_d      = state_q;
      mar_d        = mar_q;
      bus_out_d    = bus_out_q;
      bus_drive_d  = 1'b0;
      data_valid_d = 1'b0;
`ifdef RAM_WRITE_EN
      ram_wr_en    = 1'b0;
      req_err_d    = req_err_q | (ram_read & ram_write);
`endif
      if (mar_load) begin
         mar_d = bus_in[3:0];
      end
      case (state_q)
         IDLE: begin
            // A read requested together with a MAR load waits one edge so it sees the new address.
            if (ram_read && !mar_load) begin
               state_d      = READ;
               bus_out_d    = rd_dat;
               bus_drive_d  = 1'b1;
               data_valid_d = 1'b1;
            end
`ifdef RAM_WRITE_EN
            else if (ram_write && !ram_read && !mar_load) begin
               state_d   = WRITE;
               ram_wr_en = 1'b1;
            end
`endif
         end
         READ: begin
            if (!ram_read) begin
               state_d = IDLE;
            end else if (mar_load) begin
               // Keep owning the bus but flag the stale data until the new address is read.
               bus_drive_d = 1'b1;
            end else begin
               bus_out_d    = rd_dat;
               bus_drive_d  = 1'b1;
               data_valid_d = 1'b1;
            end
         end
`ifdef RAM_WRITE_EN
         WRITE: begin
            state_d = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mar_q        <= 4'h0;
         bus_out_q    <= 8'h00;
         bus_drive_q  <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mar_q        <= mar_d;
         bus_out_q    <= bus_out_d;
         bus_drive_q  <= bus_drive_d;
         data_valid_q <= data_valid_d;
      end
   end

`ifdef RAM_WRITE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_err_q <= 1'b0;
      end else begin
         req_err_q <= req_err_d;
      end
   end

   assign req_err = req_err_q;
`else
   assign req_err = 1'b0;
`endif

   // Storage survives reset; prog_we takes priority over a bus write to the same address.
   always_ff @(posedge clk) begin
`ifdef RAM_WRITE_EN
      if (ram_wr_en) begin
         mem_q[mar_q] <= bus_in;
      end
`endif
      if (prog_we) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mar_load;
   logic       ram_read;
`ifdef RAM_WRITE_EN
   logic       ram_write;
`endif
   logic [7:0] bus_in;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [7:0] bus_out;
   logic       bus_drive;
   logic       data_valid;
   logic [3:0] mar_q;
   logic       req_err;

   logic [7:0] model [16];
   logic [7:0] sb [$];
   logic [7:0] exp_dat;
   int         n_tests = 0;
   int         n_fail  = 0;

   memory_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mar_load   (mar_load),
      .ram_read   (ram_read),
`ifdef RAM_WRITE_EN
      .ram_write  (ram_write),
`endif
      .bus_in     (bus_in),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .bus_out    (bus_out),
      .bus_drive  (bus_drive),
      .data_valid (data_valid),
      .mar_q      (mar_q),
      .req_err    (req_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [3:0] a, input logic [7:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
      model[a] = d;
   endtask

   task automatic test_reset();
      #2;
      n_tests++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
      n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL reset_drive: got %b want 0", bus_drive); end
      n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
      n_tests++; if (mar_q !== 4'h0) begin n_fail++; $display("FAIL reset_mar: got %h want 0", mar_q); end
      n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", req_err); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_read();
      prog(4'h5, 8'hA7);
      prog(4'h3, 8'h3C);
      prog(4'h2, 8'h11);
      bus_in = 8'h05; mar_load = 1'b1;
      tick();
      mar_load = 1'b0;
      n_tests++; if (mar_q !== 4'h5) begin n_fail++; $display("FAIL basic_mar: got %h want 5", mar_q); end
      n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL basic_idle_drive: got %b want 0", bus_drive); end
      ram_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(model[5]);
         tick();
         n_tests++; if (bus_drive !== 1'b1) begin n_fail++; $display("FAIL basic_drive[%0d]: got %b want 1", i, bus_drive); end
         n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b want 1", i, data_valid); end
         exp_dat = sb.pop_front();
         n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, bus_out, exp_dat); end
      end
      ram_read = 1'b0;
      tick();
      n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL basic_drop_drive: got %b want 0", bus_drive); end
      n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop_valid: got %b want 0", data_valid); end
      n_tests++; if (bus_out !== 8'hA7) begin n_fail++; $display("FAIL basic_hold: got %h want a7", bus_out); end
   endtask

   task automatic test_load_and_read();
      bus_in = 8'h03; mar_load = 1'b1; ram_read = 1'b1;
      tick();
      mar_load = 1'b0;
      n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ldrd_early_valid: got %b want 0", data_valid); end
      n_tests++; if (mar_q !== 4'h3) begin n_fail++; $display("FAIL ldrd_mar: got %h want 3", mar_q); end
      sb.push_back(model[3]);
      tick();
      n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ldrd_valid: got %b want 1", data_valid); end
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL ldrd_data: got %h want %h", bus_out, exp_dat); end
      ram_read = 1'b0;
      tick();
   endtask

   task automatic test_read_before_write();
      bus_in = 8'h02; mar_load = 1'b1;
      tick();
      mar_load = 1'b0; ram_read = 1'b1;
      tick();
      prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'h55;
      sb.push_back(model[2]);
      model[2] = 8'h55;
      tick();
      prog_we = 1'b0;
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL rbw_old: got %h want %h", bus_out, exp_dat); end
      sb.push_back(model[2]);
      tick();
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL rbw_new: got %h want %h", bus_out, exp_dat); end
      ram_read = 1'b0;
      tick();
   endtask

   task automatic test_mar_reload_in_read();
      bus_in = 8'h03; mar_load = 1'b1;
      tick();
      mar_load = 1'b0; ram_read = 1'b1;
      tick();
      bus_in = 8'h05; mar_load = 1'b1;
      tick();
      mar_load = 1'b0;
      n_tests++; if (bus_drive !== 1'b1) begin n_fail++; $display("FAIL reload_drive: got %b want 1", bus_drive); end
      n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reload_valid_gap: got %b want 0", data_valid); end
      sb.push_back(model[5]);
      tick();
      n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL reload_valid: got %b want 1", data_valid); end
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL reload_data: got %h want %h", bus_out, exp_dat); end
   endtask

   task automatic test_async_reset();
      // Enters still reading address 5 from the previous scenario.
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL arst_drive: got %b want 0", bus_drive); end
      n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", data_valid); end
      n_tests++; if (mar_q !== 4'h0) begin n_fail++; $display("FAIL arst_mar: got %h want 0", mar_q); end
      ram_read = 1'b0;
      sb.delete();
      #2;
      rst_n = 1'b1;
      tick();
      n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got %b want 0", bus_drive); end
      bus_in = 8'h05; mar_load = 1'b1;
      tick();
      mar_load = 1'b0; ram_read = 1'b1;
      sb.push_back(model[5]);
      tick();
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL arst_mem_kept: got %h want %h", bus_out, exp_dat); end
      ram_read = 1'b0;
      tick();
   endtask

`ifdef RAM_WRITE_EN
   task automatic test_write();
      bus_in = 8'h09; mar_load = 1'b1;
      tick();
      mar_load = 1'b0; ram_write = 1'b1; bus_in = 8'h81;
      model[9] = 8'h81;
      tick();
      ram_write = 1'b0;
      n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL wr_drive: got %b want 0", bus_drive); end
      tick();
      ram_read = 1'b1;
      sb.push_back(model[9]);
      tick();
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL wr_readback: got %h want %h", bus_out, exp_dat); end
      ram_read = 1'b0;
      tick();
      n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_clean: got %b want 0", req_err); end
      ram_read = 1'b1; ram_write = 1'b1; bus_in = 8'hFF;
      sb.push_back(model[9]);
      tick();
      ram_read = 1'b0; ram_write = 1'b0;
      n_tests++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL conflict_err: got %b want 1", req_err); end
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL conflict_read: got %h want %h", bus_out, exp_dat); end
      tick();
      tick();
      ram_read = 1'b1;
      sb.push_back(model[9]);
      tick();
      ram_read = 1'b0;
      exp_dat = sb.pop_front();
      n_tests++; if (bus_out !== exp_dat) begin n_fail++; $display("FAIL conflict_mem_kept: got %h want %h", bus_out, exp_dat); end
      n_tests++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky: got %b want 1", req_err); end
      tick();
   endtask
`else
   task automatic test_no_write();
      ram_read = 1'b1; bus_in = 8'hFF;
      tick();
      ram_read = 1'b0;
      tick();
      n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL no_write_err: got %b want 0", req_err); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; mar_load = 1'b0; ram_read = 1'b0; bus_in = 8'h00;
      prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
`ifdef RAM_WRITE_EN
      ram_write = 1'b0;
`endif
      test_reset();
      test_basic_read();
      test_load_and_read();
      test_read_before_write();
      test_mar_reload_in_read();
      test_async_reset();
`ifdef RAM_WRITE_EN
      test_write();
`else
      test_no_write();
`endif
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries want 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
